// File: rtl/radio_frame_deser.sv
// ---------------------------------------------------------------------------
// radio_frame_deser
//
// Receive-side deserializer for the serial stream coming from a radio module.
// One bit arrives per clock, LSB first, eight bits per frame. A sync marker
// flags bit 0 of each frame. A HUNT / VERIFY / LOCKED state machine makes
// sure that words are only handed to the correlator capture logic after the
// framing has been seen to be stable for LOCK_FRAMES consecutive frames.
//
// Optional feature macro: RADIO_FRAME_DESER_ERRCNT_EN
//   When it is defined, a saturating counter of bad frames seen while LOCKED
//   is kept and exported on sync_err_cnt_o. Only reset clears it.
//   When it is undefined, the port and the counter are absent.
//
// Ports:
//   sys_clk_i       serial bit clock, one DATA bit per rising edge
//   rst_i           asynchronous active-high reset
//   data_in_i       serial data, bit 0 of the word first
//   sync_in_i       frame marker, high while bit 0 is on data_in_i
//   data_out_o      reassembled word {R0_I, R0_Q, R1_I, R1_Q}, 2 bits each
//   data_valid_o    one-cycle strobe, data_out_o is valid while high
//   locked_o        high while the framer is in the LOCKED state
//   sync_err_cnt_o  saturating bad-frame count (optional feature only)
// ---------------------------------------------------------------------------
module radio_frame_deser #(
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_MISSES = 2,
    parameter int ERR_W         = 16
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             data_in_i,
    input  logic             sync_in_i,
    output logic [7:0]       data_out_o,
    output logic             data_valid_o,
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
    output logic [ERR_W-1:0] sync_err_cnt_o,
`endif
    output logic             locked_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [3:0]  good_cnt_q;
    logic [3:0]  miss_cnt_q;
    logic        frame_bad_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        locked_q;
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;
`endif

    logic [7:0]  word_d;
    logic        frame_bad_d;
    logic [3:0]  good_cnt_d;
    logic [3:0]  miss_cnt_d;

    // The word completes with the bit on the wire at the bit-7 edge, so the
    // word is the live input on top of the seven previously sampled bits.
    // Only seven history bits are ever needed, which is why shift_q is 7 wide.
    // A frame turns bad on any sync violation: missing at bit 0 or present at
    // bits 1..7. The sticky flag makes multiple violations count only once.
    always_comb begin
        word_d      = {data_in_i, shift_q};
        frame_bad_d = frame_bad_q |
                      ((bit_cnt_q == 3'd0) ? ~sync_in_i : sync_in_i);
        good_cnt_d  = good_cnt_q + 4'd1;
        miss_cnt_d  = miss_cnt_q + 4'd1;
    end

    // Framing state machine with all outputs registered.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            good_cnt_q   <= 4'd0;
            miss_cnt_q   <= 4'd0;
            frame_bad_q  <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            shift_q      <= word_d[7:1];
            data_valid_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    bit_cnt_q   <= 3'd0;
                    frame_bad_q <= 1'b0;
                    if (sync_in_i) begin
                        bit_cnt_q  <= 3'd1;
                        good_cnt_q <= 4'd0;
                        state_q    <= VERIFY;
                    end
                end
                VERIFY: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        frame_bad_q <= 1'b0;
                        if (frame_bad_d) begin
                            state_q <= HUNT;
                        end else begin
                            good_cnt_q <= good_cnt_d;
                            if (good_cnt_d == 4'(LOCK_FRAMES)) begin
                                state_q      <= LOCKED;
                                locked_q     <= 1'b1;
                                miss_cnt_q   <= 4'd0;
                                data_out_q   <= word_d;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        frame_bad_q <= frame_bad_d;
                    end
                end
                LOCKED: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        frame_bad_q <= 1'b0;
                        if (!frame_bad_d) begin
                            data_out_q   <= word_d;
                            data_valid_q <= 1'b1;
                            miss_cnt_q   <= 4'd0;
                        end else begin
                            miss_cnt_q <= miss_cnt_d;
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
`endif
                            if (miss_cnt_d == 4'(UNLOCK_MISSES)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end else begin
                        frame_bad_q <= frame_bad_d;
                    end
                end
                default: begin
                    state_q   <= HUNT;
                    bit_cnt_q <= 3'd0;
                end
            endcase
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign locked_o     = locked_q;
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
    assign sync_err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_radio_frame_deser.sv
// ---------------------------------------------------------------------------
// tb_radio_frame_deser
//
// Drives frames into radio_frame_deser and compares its outputs on every
// cycle against a frame-level behavioural model. The model collects the eight
// (data, sync) pairs of a frame and judges the whole frame at once. Directed
// scenarios also pin hand-computed literal results.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_radio_frame_deser;

    localparam int LOCK_FRAMES   = 4;
    localparam int UNLOCK_MISSES = 2;
    localparam int ERR_W         = 16;
    localparam int ERR_MAX       = (1 << ERR_W) - 1;

    logic       clock;
    logic       reset;
    logic       dataIn;
    logic       syncIn;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       locked;
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
    logic [ERR_W-1:0] syncErrCnt;
`endif

    int testsRun;
    int testsFailed;

    // Model state: mode 0 = hunting, 1 = verifying, 2 = locked.
    int         mMode;
    int         mPos;
    int         mGoodRun;
    int         mMissRun;
    logic [7:0] mData;
    logic [7:0] mSync;
    logic [7:0] expOut;
    logic       expValid;
    logic       expLocked;
    int         expErr;

    logic [7:0] obsStrobes[$];

    radio_frame_deser #(
        .LOCK_FRAMES  (LOCK_FRAMES),
        .UNLOCK_MISSES(UNLOCK_MISSES),
        .ERR_W        (ERR_W)
    ) dut (
        .sys_clk_i     (clock),
        .rst_i         (reset),
        .data_in_i     (dataIn),
        .sync_in_i     (syncIn),
        .data_out_o    (dataOut),
        .data_valid_o  (dataValid),
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
        .sync_err_cnt_o(syncErrCnt),
`endif
        .locked_o      (locked)
    );

    // Free-running serial bit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the model's expectation.
    task automatic checkOutput();
        checkVal("data_valid", 32'(dataValid), 32'(expValid));
        checkVal("locked", 32'(locked), 32'(expLocked));
        checkVal("data_out", 32'(dataOut), 32'(expOut));
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
        checkVal("sync_err_cnt", 32'(syncErrCnt), 32'(expErr));
`endif
    endtask

    task automatic modelReset();
        mMode     = 0;
        mPos      = 0;
        mGoodRun  = 0;
        mMissRun  = 0;
        mData     = 8'h00;
        mSync     = 8'h00;
        expOut    = 8'h00;
        expValid  = 1'b0;
        expLocked = 1'b0;
        expErr    = 0;
    endtask

    // Frame-level model: gather a whole frame, then judge it as a unit.
    task automatic modelStep(input logic d, input logic s);
        logic good;
        expValid = 1'b0;
        if (mMode == 0) begin
            if (s) begin
                mData    = 8'h00;
                mSync    = 8'h00;
                mData[0] = d;
                mSync[0] = 1'b1;
                mPos     = 1;
                mGoodRun = 0;
                mMode    = 1;
            end
        end else begin
            mData[mPos] = d;
            mSync[mPos] = s;
            mPos++;
            if (mPos == 8) begin
                mPos = 0;
                good = (mSync == 8'h01);
                if (mMode == 1) begin
                    if (!good) begin
                        mMode = 0;
                    end else begin
                        mGoodRun++;
                        if (mGoodRun == LOCK_FRAMES) begin
                            mMode     = 2;
                            mMissRun  = 0;
                            expLocked = 1'b1;
                            expOut    = mData;
                            expValid  = 1'b1;
                        end
                    end
                end else begin
                    if (good) begin
                        expOut   = mData;
                        expValid = 1'b1;
                        mMissRun = 0;
                    end else begin
                        mMissRun++;
                        if (expErr < ERR_MAX) expErr++;
                        if (mMissRun == UNLOCK_MISSES) begin
                            mMode     = 0;
                            expLocked = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    // One serial bit: drive at the falling edge, let the DUT sample it,
    // advance the model, and compare just after the rising edge.
    task automatic applyStimulus(input logic d, input logic s);
        @(negedge clock);
        dataIn = d;
        syncIn = s;
        @(posedge clock);
        modelStep(d, s);
        #1;
        checkOutput();
        if (dataValid === 1'b1) obsStrobes.push_back(dataOut);
    endtask

    task automatic sendFrame(input logic [7:0] word, input logic [7:0] mask);
        for (int i = 0; i < 8; i++) applyStimulus(word[i], mask[i]);
    endtask

    // Assert reset away from the clock edges and check outputs clear at once.
    task automatic applyReset();
        #2;
        reset  = 1'b1;
        dataIn = 1'b0;
        syncIn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        obsStrobes.delete();
    endtask

    task automatic lockUp();
        sendFrame(8'h12, 8'h01);
        sendFrame(8'h34, 8'h01);
        sendFrame(8'h56, 8'h01);
        sendFrame(8'h78, 8'h01);
    endtask

    // Directed scenarios, then a randomized soak.
    initial begin
        int badShift;
        int sizeBefore;
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        dataIn      = 1'b0;
        syncIn      = 1'b0;
        modelReset();

        // Clean stream: lock after the fourth frame, first word 0x44.
        applyReset();
        checkVal("reset_data_out", 32'(dataOut), 32'h00);
        checkVal("reset_locked", 32'(locked), 32'h0);
        sendFrame(8'h11, 8'h01);
        sendFrame(8'h22, 8'h01);
        sendFrame(8'h33, 8'h01);
        checkVal("t1_no_lock_yet", 32'(locked), 32'h0);
        checkVal("t1_no_strobe_yet", 32'(obsStrobes.size()), 32'd0);
        sendFrame(8'h44, 8'h01);
        checkVal("t1_strobes_after4", 32'(obsStrobes.size()), 32'd1);
        checkVal("t1_first_word", 32'(obsStrobes[0]), 32'h44);
        checkVal("t1_locked", 32'(locked), 32'h1);
        sendFrame(8'hA5, 8'h01);
        checkVal("t1_strobes_after5", 32'(obsStrobes.size()), 32'd2);
        checkVal("t1_second_word", 32'(obsStrobes[1]), 32'hA5);

        // Mid-frame start: five junk bits, then alternating 0x0F / 0xF0.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        for (int f = 0; f < 8; f++) sendFrame((f % 2 == 0) ? 8'h0F : 8'hF0, 8'h01);
        badShift = 0;
        foreach (obsStrobes[i]) if (obsStrobes[i] != 8'h0F && obsStrobes[i] != 8'hF0) badShift++;
        checkVal("t2_strobe_count", 32'(obsStrobes.size()), 32'd5);
        checkVal("t2_misaligned_words", 32'(badShift), 32'd0);

        // Single missed sync while locked.
        applyReset();
        lockUp();
        sizeBefore = obsStrobes.size();
        sendFrame(8'h5A, 8'h00);
        checkVal("t3_no_strobe", 32'(obsStrobes.size()), 32'(sizeBefore));
        checkVal("t3_still_locked", 32'(locked), 32'h1);
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
        checkVal("t3_err_cnt", 32'(syncErrCnt), 32'd1);
`endif
        sendFrame(8'hC3, 8'h01);
        checkVal("t3_recover_word", 32'(obsStrobes[obsStrobes.size()-1]), 32'hC3);
        sendFrame(8'h66, 8'h00);
        checkVal("t3_miss_cleared", 32'(locked), 32'h1);

        // Two consecutive misses drop lock; relock needs four frames.
        applyReset();
        lockUp();
        sendFrame(8'h99, 8'h00);
        checkVal("t4_locked_after_1miss", 32'(locked), 32'h1);
        sendFrame(8'h98, 8'h00);
        checkVal("t4_unlocked_after_2miss", 32'(locked), 32'h0);
        sendFrame(8'h01, 8'h01);
        sendFrame(8'h02, 8'h01);
        sendFrame(8'h03, 8'h01);
        checkVal("t4_not_relocked_3", 32'(locked), 32'h0);
        sendFrame(8'h04, 8'h01);
        checkVal("t4_relocked_4", 32'(locked), 32'h1);
        checkVal("t4_relock_word", 32'(obsStrobes[obsStrobes.size()-1]), 32'h04);
`ifdef RADIO_FRAME_DESER_ERRCNT_EN
        checkVal("t4_err_cnt", 32'(syncErrCnt), 32'd2);
`endif

        // Extra sync during verification sends the framer back to hunting.
        applyReset();
        sendFrame(8'hAA, 8'h01);
        sendFrame(8'hBB, 8'h01);
        sendFrame(8'hCC, 8'h09);
        sendFrame(8'h10, 8'h01);
        sendFrame(8'h20, 8'h01);
        sendFrame(8'h30, 8'h01);
        checkVal("t5_not_locked", 32'(locked), 32'h0);
        checkVal("t5_no_strobe", 32'(obsStrobes.size()), 32'd0);
        sendFrame(8'h40, 8'h01);
        checkVal("t5_locked", 32'(locked), 32'h1);
        checkVal("t5_word", 32'(obsStrobes[0]), 32'h40);

        // Reset mid-frame while locked, then a normal relock.
        applyReset();
        lockUp();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyReset();
        checkVal("t6_data_out_zero", 32'(dataOut), 32'h00);
        checkVal("t6_locked_zero", 32'(locked), 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        checkVal("t6_no_spurious", 32'(obsStrobes.size()), 32'd0);
        lockUp();
        checkVal("t6_relocked", 32'(locked), 32'h1);

        // Randomized soak: mostly clean frames, some corrupted, random gaps.
        applyReset();
        for (int f = 0; f < 300; f++) begin
            logic [7:0] w;
            logic [7:0] m;
            w = 8'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
            sendFrame(w, m);
            if ($urandom_range(0, 9) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    applyStimulus(1'($urandom), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
